// File: rtl/cbus_arbiter_if.sv
// cbus_pkg + cbus_arbiter_if
//
// Purpose: shared cache-bus request/response types and the bundle of
// arbiter-facing signals.
//
// Signals:
//   ireqs  [NUM_MASTERS] : per-master cbus requests into the arbiter
//   iresps [NUM_MASTERS] : per-master cbus responses out of the arbiter
//   oreq                 : request forwarded to the external cbus
//   oresp                : response returned by the external cbus
// Modports:
//   slave  : arbiter view (consumes ireqs/oresp, drives iresps/oreq)
//   master : environment view (masters plus external bus model)

package cbus_pkg;

    typedef enum logic [1:0] {
        MLEN1 = 2'd0,
        MLEN2 = 2'd1,
        MLEN4 = 2'd2,
        MLEN8 = 2'd3
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    import cbus_pkg::*;

    cbus_req_t  [NUM_MASTERS-1:0] ireqs;
    cbus_resp_t [NUM_MASTERS-1:0] iresps;
    cbus_req_t                    oreq;
    cbus_resp_t                   oresp;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq
    );

endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter
//
// Purpose: shares one external cache bus among NUM_MASTERS cache-side ports.
// One port is granted at a time and keeps the grant for a whole transaction
// (burst refill, write-back or single uncached beat) until the beat carrying
// oresp.last is accepted. Arbitration takes one idle cycle, so back-to-back
// transactions are separated by at least one bubble.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset
//   bus      : cbus_arbiter_if.slave (ireqs, iresps, oreq, oresp)
//   busy     : a transaction is granted and in flight
//   owner    : index of the granted master (meaningful while busy)
//   beat_cnt : beats accepted in the current transaction, saturating at 255

// Per-port response steering: a port sees the external response only while
// it owns the bus, otherwise all-zero (ready=0 stalls it).
module cbus_resp_lane
    import cbus_pkg::*;
(
    input  logic       sel,
    input  cbus_resp_t oresp,
    output cbus_resp_t iresp
);
    assign iresp = sel ? oresp : '0;
endmodule

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,   // at least 2
    parameter int ROUND_ROBIN = 1,
    parameter int OWNER_BITS  = $clog2(NUM_MASTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    cbus_arbiter_if.slave         bus,
    output logic                  busy,
    output logic [OWNER_BITS-1:0] owner,
    output logic [7:0]            beat_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [OWNER_BITS-1:0]   owner_q, owner_d;
    logic [OWNER_BITS-1:0]   last_grant_q, last_grant_d;
    logic [7:0]              beat_q, beat_d;

    logic [NUM_MASTERS-1:0]  req_vld;
    logic                    any_valid;
    logic [OWNER_BITS-1:0]   winner;
    logic [OWNER_BITS-1:0]   cand;

    cbus_resp_t [NUM_MASTERS-1:0] iresps_w;

    // ------------------------------------------------------------------
    // Request valid vector and per-port response lanes
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
        assign req_vld[i] = bus.ireqs[i].valid;

        cbus_resp_lane u_lane (
            .sel   ((state_q == BUSY) && (owner_q == OWNER_BITS'(i))),
            .oresp (bus.oresp),
            .iresp (iresps_w[i])
        );
    end

    assign bus.iresps = iresps_w;

    // Only the owner's request reaches the external bus; it is forwarded
    // as-is, including a dropped valid, so the bus sees exactly what the
    // master drives.
    assign bus.oreq = (state_q == BUSY) ? bus.ireqs[owner_q] : '0;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    // Candidates are scanned from the lowest priority to the highest so the
    // final assignment is the highest-priority valid port.
    always_comb begin
        any_valid = |req_vld;
        winner    = '0;
        cand      = '0;
        if (ROUND_ROBIN != 0) begin
            // Priority order: last_grant+1, last_grant+2, ... wrapping.
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                cand = OWNER_BITS'((int'(last_grant_q) + k) % NUM_MASTERS);
                if (req_vld[cand])
                    winner = cand;
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (req_vld[k])
                    winner = OWNER_BITS'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                // oresp is ignored here; nothing is in flight.
                if (any_valid) begin
                    owner_d = winner;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.oresp.ready) begin
                    if (beat_q != 8'hFF)
                        beat_d = beat_q + 8'd1;
                    // Release only on last; no same-cycle regrant.
                    if (bus.oresp.last) begin
                        last_grant_d = owner_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            // Point at the top port so port 0 is first in line.
            last_grant_q <= OWNER_BITS'(NUM_MASTERS - 1);
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign owner    = owner_q;
    assign beat_cnt = beat_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter
//
// Directed bench: a round-robin and a fixed-priority arbiter are driven with
// identical stimulus. A vector table covers single-master bursts, idle
// response noise, owner valid-drop and a contested pair; hand-written
// sequences cover grant ordering, an uncached write and reset mid-burst.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy_rr, busy_fp;
    logic [0:0] owner_rr, owner_fp;
    logic [7:0] beat_rr, beat_fp;

    int n_chk  = 0;
    int n_fail = 0;

    cbus_req_t base0, base1;

    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_MASTERS(2)) bus_rr ();
    cbus_arbiter_if #(.NUM_MASTERS(2)) bus_fp ();

    cbus_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(1)) dut_rr (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus_rr.slave),
        .busy     (busy_rr),
        .owner    (owner_rr),
        .beat_cnt (beat_rr)
    );

    cbus_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(0)) dut_fp (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus_fp.slave),
        .busy     (busy_fp),
        .owner    (owner_fp),
        .beat_cnt (beat_fp)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v0, input logic v1, input logic rdy,
                          input logic lst, input logic [31:0] d);
        cbus_req_t  r0, r1;
        cbus_resp_t rs;
        r0 = base0;  r0.valid = v0;
        r1 = base1;  r1.valid = v1;
        rs.ready = rdy;
        rs.last  = lst;
        rs.data  = d;
        bus_rr.ireqs[0] = r0;  bus_rr.ireqs[1] = r1;  bus_rr.oresp = rs;
        bus_fp.ireqs[0] = r0;  bus_fp.ireqs[1] = r1;  bus_fp.oresp = rs;
    endtask

    // Bounded wait for the round-robin arbiter to grant; timeout is a failure.
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!busy_rr && n < 8);
        chk("grant_wait", busy_rr, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v0, v1, rdy, lst;
        logic [31:0] d;
        logic        e_busy;
        logic        e_owner;
        logic        e_ov;
        logic [31:0] e_oaddr;
        logic        e_r0, e_r1;   // port receives oresp this cycle
        logic [7:0]  e_beat;
    } vec_t;

    vec_t vt[14];

    initial begin
        int           n;
        logic         exp_rr[3];
        cbus_req_t    wr_req;
        cbus_resp_t   exp_resp;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n;
        logic       exp_rr[3];
        cbus_req_t  wr_req;
        cbus_resp_t exp_resp;

        base0 = '{valid: 1'b0, is_write: 1'b0, size: 3'd2, addr: 32'h8000_0000,
                  strobe: 4'hF, data: 32'h0, len: MLEN4};
        base1 = base0;
        base1.addr = 32'h8000_0100;

        //          v0 v1 rdy lst data          busy own ov addr          r0 r1 beat
        vt[0]  = '{0, 0, 1, 1, 32'h99,        0, 0, 0, 32'h0,          0, 0, 8'd0};
        vt[1]  = '{0, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 8'd0};
        vt[2]  = '{0, 1, 1, 0, 32'h11,        1, 1, 1, 32'h8000_0100,  0, 1, 8'd0};
        vt[3]  = '{0, 1, 1, 0, 32'h22,        1, 1, 1, 32'h8000_0100,  0, 1, 8'd1};
        vt[4]  = '{0, 0, 1, 0, 32'h33,        1, 1, 0, 32'h8000_0100,  0, 1, 8'd2};
        vt[5]  = '{0, 1, 1, 1, 32'h44,        1, 1, 1, 32'h8000_0100,  0, 1, 8'd3};
        vt[6]  = '{0, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 0, 8'd4};
        vt[7]  = '{1, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 0, 8'd4};
        vt[8]  = '{1, 1, 1, 0, 32'h55,        1, 0, 1, 32'h8000_0000,  1, 0, 8'd0};
        vt[9]  = '{1, 1, 1, 1, 32'h66,        1, 0, 1, 32'h8000_0000,  1, 0, 8'd1};
        vt[10] = '{1, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 8'd2};
        vt[11] = '{1, 1, 0, 0, 32'h0,         1, 1, 1, 32'h8000_0100,  0, 1, 8'd0};
        vt[12] = '{0, 1, 1, 1, 32'h77,        1, 1, 1, 32'h8000_0100,  0, 1, 8'd0};
        vt[13] = '{0, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 0, 8'd1};

        // Reset state, with live inputs to show nothing leaks through.
        rst = 1'b1;
        set_in(1, 1, 1, 1, 32'hAB);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",   busy_rr, 1'b0);
        chk("rst_owner",  owner_rr, 1'b0);
        chk("rst_beat",   beat_rr, 8'd0);
        chk("rst_oreq",   bus_rr.oreq, '0);
        chk("rst_iresps", bus_rr.iresps, '0);
        set_in(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors on the round-robin arbiter.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_in(vt[i].v0, vt[i].v1, vt[i].rdy, vt[i].lst, vt[i].d);
            #1;
            chk($sformatf("v%0d_busy", i),  busy_rr, vt[i].e_busy);
            chk($sformatf("v%0d_owner", i), owner_rr, vt[i].e_owner);
            chk($sformatf("v%0d_beat", i),  beat_rr, vt[i].e_beat);
            chk($sformatf("v%0d_ovalid", i), bus_rr.oreq.valid, vt[i].e_ov);
            chk($sformatf("v%0d_oaddr", i), bus_rr.oreq.addr, vt[i].e_oaddr);
            exp_resp = '{ready: vt[i].rdy, last: vt[i].lst, data: vt[i].d};
            chk($sformatf("v%0d_iresp0", i), bus_rr.iresps[0], vt[i].e_r0 ? exp_resp : '0);
            chk($sformatf("v%0d_iresp1", i), bus_rr.iresps[1], vt[i].e_r1 ? exp_resp : '0);
        end

        // Contested grants: both ports always valid, 2-beat transactions.
        // Round robin alternates 0,1,0; fixed priority stays on port 0.
        base0.len = MLEN2;
        base1.len = MLEN2;
        exp_rr[0] = 1'b0;  exp_rr[1] = 1'b1;  exp_rr[2] = 1'b0;
        pulse_reset();
        set_in(1, 1, 0, 0, 32'h0);
        for (int t = 0; t < 3; t++) begin
            if (t != 0)
                chk($sformatf("c%0d_gap_idle", t), busy_rr, 1'b0);
            wait_grant(n);
            chk($sformatf("c%0d_grant_lat", t), n, 1);
            chk($sformatf("c%0d_owner_rr", t), owner_rr, exp_rr[t]);
            chk($sformatf("c%0d_owner_fp", t), {busy_fp, owner_fp}, 2'b10);
            set_in(1, 1, 1, 0, 32'hC0 + t);
            #1;
            chk($sformatf("c%0d_own_ready", t), bus_rr.iresps[exp_rr[t]].ready, 1'b1);
            chk($sformatf("c%0d_lose_ready", t), bus_rr.iresps[~exp_rr[t]].ready, 1'b0);
            @(negedge clk);
            set_in(1, 1, 1, 1, 32'hD0 + t);
            #1;
            chk($sformatf("c%0d_last", t), bus_rr.iresps[exp_rr[t]].last, 1'b1);
            @(negedge clk);
            set_in(1, 1, 0, 0, 32'h0);
            #1;
        end

        // Uncached single-beat write from port 1, forwarded unchanged.
        pulse_reset();
        base1 = '{valid: 1'b0, is_write: 1'b1, size: 3'd2, addr: 32'h9000_0004,
                  strobe: 4'b0011, data: 32'hDEAD_BEEF, len: MLEN1};
        wr_req = base1;
        wr_req.valid = 1'b1;
        set_in(0, 1, 0, 0, 32'h0);
        wait_grant(n);
        chk("wr_owner", owner_rr, 1'b1);
        chk("wr_oreq",  bus_rr.oreq, wr_req);
        set_in(0, 1, 1, 1, 32'h1234);
        #1;
        chk("wr_resp", bus_rr.iresps[1], {1'b1, 1'b1, 32'h1234});
        @(negedge clk);
        set_in(0, 0, 0, 0, 32'h0);
        #1;
        chk("wr_done", {busy_rr, beat_rr}, {1'b0, 8'd1});
        @(negedge clk);
        #1;
        chk("wr_stays_idle", busy_rr, 1'b0);

        // Reset asserted during the 2nd beat of a port-1 burst.
        base1 = base0;
        base1.addr = 32'h8000_0100;
        base1.len  = MLEN4;
        pulse_reset();
        set_in(0, 1, 0, 0, 32'h0);
        wait_grant(n);
        chk("mr_owner", owner_rr, 1'b1);
        set_in(0, 1, 1, 0, 32'h11);
        @(negedge clk);
        set_in(0, 1, 1, 0, 32'h22);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_busy",   busy_rr, 1'b0);
        chk("mr_owner0", owner_rr, 1'b0);
        chk("mr_beat",   beat_rr, 8'd0);
        chk("mr_oreq",   bus_rr.oreq, '0);
        chk("mr_iresps", bus_rr.iresps, '0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 1, 0, 0, 32'h0);
        wait_grant(n);
        chk("mr_regrant_owner", owner_rr, 1'b0);
        chk("mr_regrant_addr",  bus_rr.oreq.addr, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
